hazard_scoreboard: RTL and testbench

- Parametrised, stateful successor to the combinational forwarding/stall controller of the RV32I pipeline.
- Holds a shift-register scoreboard of in-flight producers (valid, rd, writes-rd, is-load) for every stage after ID.
- From that scoreboard it generates per-source forwarding selects and a load-use stall for the instruction in ID.
- Pipeline depth and load-data readiness stage are parameters, so the block survives pipeline re-partitioning.

---
 rtl/hazard_scoreboard.sv | 135 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Shift-register hazard scoreboard: tracks in-flight producers after ID and derives
// per-source forwarding selects plus a load-use stall. Define HAZARD_STATS_EN for stall/flush counters.
module hazard_scoreboard #(
    parameter int unsigned REG_AW           = 5,
    parameter int unsigned DEPTH            = 3,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned SEL_W            = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic              flush,
    input  logic              hold,
    output logic              stall_id,
    output logic [SEL_W-1:0]  fwd_sel_rs1,
    output logic [SEL_W-1:0]  fwd_sel_rs2
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    localparam int unsigned NSRC = 2;
    localparam logic [SEL_W-1:0] LRS_SEL = SEL_W'(LOAD_READY_STAGE);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } entry_t;

    entry_t ent_q [1:DEPTH];
    entry_t ent_d [1:DEPTH];

    logic [REG_AW-1:0] src     [NSRC];
    logic              used    [NSRC];
    logic [SEL_W-1:0]  sel_hit [NSRC];
    logic              ld_hit  [NSRC];
    logic              haz     [NSRC];

    // Source lookup: scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        src[0]  = id_rs1;
        src[1]  = id_rs2;
        used[0] = id_rs1_used;
        used[1] = id_rs2_used;
        for (int s = 0; s < int'(NSRC); s++) begin
            sel_hit[s] = '0;
            ld_hit[s]  = 1'b0;
            for (int k = int'(DEPTH); k >= 1; k--) begin
                if (id_valid && used[s] && (src[s] != '0) &&
                    ent_q[k].v && ent_q[k].wr && (ent_q[k].rd == src[s])) begin
                    sel_hit[s] = SEL_W'(k);
                    ld_hit[s]  = ent_q[k].ld;
                end
            end
            haz[s] = ld_hit[s] && (sel_hit[s] < LRS_SEL);
        end
    end

    // Flush squashes ID, so it overrides any load-use stall.
    always_comb begin
        stall_id    = (haz[0] || haz[1]) && !flush;
        fwd_sel_rs1 = haz[0] ? '0 : sel_hit[0];
        fwd_sel_rs2 = haz[1] ? '0 : sel_hit[1];
    end

    // Advance the scoreboard one stage unless held; ID enters only if it really issues.
    always_comb begin
        for (int k = 1; k <= int'(DEPTH); k++) begin
            ent_d[k] = ent_q[k];
        end
        if (!hold) begin
            for (int k = int'(DEPTH); k >= 2; k--) begin
                ent_d[k] = ent_q[k-1];
            end
            ent_d[1] = '0;
            if (id_valid && !stall_id && !flush) begin
                ent_d[1] = '{v: 1'b1, rd: id_rd, wr: id_wr, ld: id_is_load};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_id && !hold && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-style behavioural model.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int LRS   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_wr, id_is_load, id_rs1_used, id_rs2_used, flush, hold;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       stall_id;
    logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
    logic [31:0] m_sc, m_fc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit         v;
        logic [4:0] rd;
        bit         wr;
        bit         ld;
    } ent_t;
    ent_t m [1:DEPTH];

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_wr       (id_wr),
        .id_is_load  (id_is_load),
        .id_rs1      (id_rs1),
        .id_rs1_used (id_rs1_used),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .flush       (flush),
        .hold        (hold),
        .stall_id    (stall_id),
        .fwd_sel_rs1 (fwd_sel_rs1),
        .fwd_sel_rs2 (fwd_sel_rs2)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 1; k <= DEPTH; k++) m[k] = '{v: 0, rd: 5'd0, wr: 0, ld: 0};
`ifdef HAZARD_STATS_EN
        m_sc = 0;
        m_fc = 0;
`endif
    endtask

    // Youngest producer of src, searched from stage 1 outward.
    function automatic void eval(input logic [4:0] src, input logic used, output int sel, output bit haz);
        sel = 0;
        haz = 0;
        if (id_valid && used && src != 5'd0) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (m[k].v && m[k].wr && m[k].rd == src) begin
                    sel = k;
                    haz = m[k].ld && (k < LRS);
                    break;
                end
            end
        end
        if (haz) sel = 0;
    endfunction

    task automatic drive(input bit v, input int rd, input bit wr, input bit ld,
                         input int r1, input bit u1, input int r2, input bit u2,
                         input bit fl, input bit hd);
        id_valid = v;  id_rd = 5'(rd); id_wr = wr; id_is_load = ld;
        id_rs1 = 5'(r1); id_rs1_used = u1; id_rs2 = 5'(r2); id_rs2_used = u2;
        flush = fl; hold = hd;
    endtask

    // Compare against the model mid-cycle, then advance the model at the clock edge.
    task automatic tick();
        int  s1, s2;
        bit  h1, h2, st;
        @(negedge clk);
        eval(id_rs1, id_rs1_used, s1, h1);
        eval(id_rs2, id_rs2_used, s2, h2);
        st = (h1 || h2) && !flush;
        check("model stall_id", stall_id, st);
        check("model fwd_sel_rs1", fwd_sel_rs1, s1);
        check("model fwd_sel_rs2", fwd_sel_rs2, s2);
`ifdef HAZARD_STATS_EN
        check("model stall_cycles", stall_cycles, m_sc);
        check("model flush_count", flush_count, m_fc);
`endif
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
`ifdef HAZARD_STATS_EN
            if (st && !hold && m_sc != 32'hFFFF_FFFF) m_sc++;
            if (flush && m_fc != 32'hFFFF_FFFF) m_fc++;
`endif
            if (!hold) begin
                for (int k = DEPTH; k >= 2; k--) m[k] = m[k-1];
                m[1] = '{v: id_valid && !st && !flush, rd: id_rd, wr: id_wr, ld: id_is_load};
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset stall_id", stall_id, 0);
        check("reset fwd_sel_rs1", fwd_sel_rs1, 0);
        check("reset fwd_sel_rs2", fwd_sel_rs2, 0);
        rst = 1'b0;

        // add x5, then add x6,x5,x5
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 6, 1, 0, 5, 1, 5, 1, 0, 0); #2;
        check("alu fwd rs1", fwd_sel_rs1, 1);
        check("alu fwd rs2", fwd_sel_rs2, 1);
        check("alu no stall", stall_id, 0);
        tick();

        // lw x5, then add x6,x5,x1: one stall cycle, then forward from stage 2
        drive(1, 5, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 0); #2;
        check("loaduse stall", stall_id, 1);
        check("loaduse sel rs1", fwd_sel_rs1, 0);
        tick();
        check("loaduse released", stall_id, 0);
        check("loaduse fwd stage2", fwd_sel_rs1, 2);
        tick();
        drive(1, 7, 1, 0, 6, 1, 0, 0, 0, 0); #2;
        check("stalled add entered", fwd_sel_rs1, 1);
        tick();

        // x0 never forwards
        drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 1, 0, 1, 0, 0); #2;
        check("x0 rs1", fwd_sel_rs1, 0);
        check("x0 rs2", fwd_sel_rs2, 0);
        check("x0 stall", stall_id, 0);
        tick();

        // x7 producers in stages 1 and 3
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 9, 1, 0, 7, 1, 0, 0, 0, 0); #2;
        check("youngest x7", fwd_sel_rs1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 9, 1, 0, 7, 1, 0, 0, 0, 0); #2;
        check("x7 at stage2", fwd_sel_rs1, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 9, 1, 0, 7, 1, 0, 0, 0, 0); #2;
        check("x7 at WB", fwd_sel_rs1, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // load-use with flush: flush wins, bubble enters
        drive(1, 10, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 11, 1, 0, 10, 1, 0, 0, 1, 0); #2;
        check("flush kills stall", stall_id, 0);
        tick();
        drive(1, 16, 1, 0, 10, 1, 11, 1, 0, 0); #2;
        check("flush lw at stage2", fwd_sel_rs1, 2);
        check("flushed not entered", fwd_sel_rs2, 0);
        tick();

        // hold freezes the scoreboard
        drive(1, 12, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 13, 1, 0, 12, 1, 0, 0, 0, 1); #2;
        check("hold stall", stall_id, 1);
        tick();
        drive(1, 13, 1, 0, 12, 1, 0, 0, 0, 0); #2;
        check("held lw still stage1", stall_id, 1);
        tick();
        check("after hold fwd stage2", fwd_sel_rs1, 2);
        tick();

        // reset mid-stream with three valid entries
        drive(1, 13, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 14, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 15, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 17, 1, 0, 15, 1, 14, 1, 0, 0); #2;
        check("pre-reset rs1", fwd_sel_rs1, 1);
        check("pre-reset rs2", fwd_sel_rs2, 2);
        rst = 1'b1;
        #1;
        check("midreset rs1", fwd_sel_rs1, 0);
        check("midreset rs2", fwd_sel_rs2, 0);
        check("midreset stall", stall_id, 0);
        model_clear();
`ifdef HAZARD_STATS_EN
        check("midreset stall_cycles", stall_cycles, 0);
        check("midreset flush_count", flush_count, 0);
`endif
        tick();
        rst = 1'b0;
        drive(1, 17, 1, 0, 15, 1, 14, 1, 0, 0); #2;
        check("post-reset rs1", fwd_sel_rs1, 0);
        check("post-reset stall", stall_id, 0);
        tick();

        // randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            id_valid    = ($urandom_range(0, 7) != 0);
            id_rd       = 5'($urandom_range(0, 3));
            id_wr       = ($urandom_range(0, 3) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs1_used = ($urandom_range(0, 3) != 0);
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs2_used = ($urandom_range(0, 1) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            hold        = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
